demux_1to2_stream: RTL
======================

Name: demux_1to2_stream

Overview:
- 1:2 stream demultiplexer: the inverse of the team's 2:1 gate mux.
- Accepts one WIDTH-bit input stream with a per-beat select bit and routes each beat to output channel 0 or 1.
- Each channel has its own 2-entry output buffer with valid/ready handshake, plus a per-channel transfer counter.
- Sits between a single producer and two independent consumers; one channel stalling does not corrupt the other.

Parameters:
- WIDTH, 8: data width of input and both outputs.
- CNT_W, 16: width of the per-channel transfer counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block accepts the beat this cycle.
- in_sel  input  1  destination: 0 → channel 0, 1 → channel 1.
- in_data  input  WIDTH  beat payload.
- out0_valid  output  1  channel 0 head valid.
- out0_ready  input  1  channel 0 consumer accepts.
- out0_data  output  WIDTH  channel 0 head data.
- out1_valid  output  1  channel 1 head valid.
- out1_ready  input  1  channel 1 consumer accepts.
- out1_data  output  WIDTH  channel 1 head data.
- out0_count  output  CNT_W  completed channel 0 transfers.
- out1_count  output  CNT_W  completed channel 1 transfers.

Behaviour:
- Reset (asynchronous, active-high): while reset is high, in_ready=0, outN_valid=0, outN_data=0, outN_count=0, buffer occupancy=0.
- Reset asserted mid-operation flushes all buffered beats immediately; the flushed data is lost.
- After reset deasserts, in_ready=1 on the first cycle (both buffers empty).
- Input transfer: occurs when in_valid && in_ready at the clock edge.
  - in_ready = ~full[in_sel]. Purely a function of in_sel and registered occupancy; no combinational path from out0_ready/out1_ready.
  - Producer must hold in_sel/in_data stable while in_valid=1 and the beat is not yet accepted.
- Buffers: each channel is a 2-entry FIFO (occupancy 0, 1 or 2; full at 2).
  - Latency: a beat accepted at edge k is visible on outN_valid/outN_data after edge k (one-cycle latency). No same-cycle bypass.
  - Output transfer occurs when outN_valid && outN_ready; the head pops at that edge.
  - Simultaneous push and pop on the same channel:
    - occupancy 1: occupancy stays 1, the new beat becomes head.
    - occupancy 2: push is impossible because in_ready=0; pop alone takes occupancy to 1, and in_ready for that channel rises next cycle.
  - Sustained rate is 1 beat/cycle per channel when the consumer is always ready.
  - Beat order is preserved within each channel. There is no ordering relation across channels.
- Head-of-line blocking: if the selected channel is full, in_ready=0 even when the other channel is empty. This is intentional.
- outN_data when outN_valid=0: holds the last head value or 0 after reset. Not checked.
- Counters: outN_count increments by 1 on each output transfer of channel N and wraps from 2^CNT_W−1 to 0.
- Outputs are registered except in_ready, which is a single mux of two registered full flags.

Decomposition:
- Shared package demux_pkg holds:
  - constant CH0=0, CH1=1
  - constant BUF_DEPTH=2
  - typedef for the occupancy count (2 bits)
- Natural sub-module: demux_chan_buf, instantiated twice. It is a 2-entry FIFO plus transfer counter.
  - Ports: clk, reset, push, push_data, full, valid, ready, data, count.
- The top level contains only select decode, push gating and the in_ready mux.

Test Plan:
- Reset check: hold reset for 3 cycles with in_valid=1 → in_ready=0, both valids 0, both counts 0. Assert reset asynchronously mid-cycle → outputs clear before the next edge.
- Routing: send 0xA5 sel=0, then 0x3C sel=1, both consumers ready → out0 shows 0xA5 one cycle after acceptance and out1 shows 0x3C likewise. Final state: out0_count=1, out1_count=1.
- Backpressure/full: out0_ready=0, send 0x01, 0x02, 0x03 to ch0 → first two accepted; in_ready=0 for 0x03 while sel=0. Raise out0_ready → 0x01, 0x02, 0x03 appear in order, and 0x03 is accepted the cycle after the first pop.
- Head-of-line blocking: ch0 full and stalled, present sel=0 then sel=1 → sel=1 beat is not accepted until ch0 drains. out1_valid stays 0 meanwhile.
- Push+pop at occupancy 1: stream 100 beats sel=1 with out1_ready=1 → in_ready stays 1 throughout, 100 beats out in order, out1_count=100.
- Counter wrap (CNT_W=4): 17 transfers on ch0 → out0_count reads 1. Reset mid-stream with 2 beats buffered → both valids drop to 0, and no stale beats appear after release.

Source files
------------

// File: rtl/demux_1to2_stream_pkg.sv
// Shared constants and types for the 1:2 stream demultiplexer and its channel buffers.
package demux_pkg;

    localparam int CH0       = 0;
    localparam int CH1       = 1;
    localparam int BUF_DEPTH = 2;

    // Occupancy of one channel buffer: 0, 1 or 2 beats.
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = occ_t'(0);
    localparam occ_t OCC_ONE   = occ_t'(1);
    localparam occ_t OCC_FULL  = occ_t'(BUF_DEPTH);

endpackage

// File: rtl/demux_1to2_stream_if.sv
// Stream bundle for the 1:2 demux: one input stream, two output streams and their transfer counters.
interface demux_1to2_stream_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;

    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    logic [CNT_W-1:0] out0_count;
    logic [CNT_W-1:0] out1_count;

    // Environment side: producer plus both consumers.
    modport master (
        output in_valid, in_sel, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data,
               out0_count, out1_count
    );

    // Demux side.
    modport slave (
        input  in_valid, in_sel, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data,
               out0_count, out1_count
    );

endinterface

// File: rtl/demux_1to2_stream_chan_buf.sv
// One output channel: 2-entry FIFO with registered head/valid/full and a wrapping transfer counter.
module demux_chan_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    occ_t             occ;
    occ_t             occ_next;
    logic [WIDTH-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = valid && ready;

    always_comb begin
        occ_next = occ;
        case ({do_push, do_pop})
            2'b10:   occ_next = occ + OCC_ONE;
            2'b01:   occ_next = occ - OCC_ONE;
            default: occ_next = occ;
        endcase
    end

    // Head lives in 'data' directly so the output is a flop; 'tail' holds the second beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ   <= OCC_EMPTY;
            valid <= 1'b0;
            full  <= 1'b0;
            data  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            occ   <= occ_next;
            valid <= (occ_next != OCC_EMPTY);
            full  <= (occ_next == OCC_FULL);
            if (do_pop) begin
                count <= count + CNT_W'(1);
            end
            if (do_push && (occ == OCC_EMPTY || (do_pop && occ == OCC_ONE))) begin
                data <= push_data;
            end else if (do_push) begin
                tail <= push_data;
            end else if (do_pop && occ == OCC_FULL) begin
                data <= tail;
            end
        end
    end

endmodule

// File: rtl/demux_1to2_stream.sv
// 1:2 stream demultiplexer: routes each input beat by in_sel into one of two buffered output channels.
module demux_1to2_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    demux_1to2_stream_if.slave    bus
);

    logic full0;
    logic full1;
    logic accept;
    logic push0;
    logic push1;

    // Selected channel's full flag alone gates the producer (head-of-line blocking is intended);
    // reset forces it low so nothing is taken while the buffers are being cleared.
    assign bus.in_ready = ~reset & ~(bus.in_sel ? full1 : full0);
    assign accept       = bus.in_valid & bus.in_ready;
    assign push0        = accept & (bus.in_sel == 1'(CH0));
    assign push1        = accept & (bus.in_sel == 1'(CH1));

    demux_chan_buf #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ch0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push0),
        .push_data (bus.in_data),
        .full      (full0),
        .valid     (bus.out0_valid),
        .ready     (bus.out0_ready),
        .data      (bus.out0_data),
        .count     (bus.out0_count)
    );

    demux_chan_buf #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ch1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push1),
        .push_data (bus.in_data),
        .full      (full1),
        .valid     (bus.out1_valid),
        .ready     (bus.out1_ready),
        .data      (bus.out1_data),
        .count     (bus.out1_count)
    );

endmodule
